// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// Module      : score_display
// Description : Final-score latch, session high score, 16-bit binary to
//               5-digit BCD conversion (sequential double-dabble) and an
//               8-digit multiplexed seven-segment display driver.
// Ports       : clk        - system clock
//               reset      - asynchronous, active-low reset
//               score_in   - live 16-bit score
//               gameover   - level, high while the game is over
//               show_high  - 1 = display high score
//               an         - digit anodes, active-low, an[0] = rightmost
//               seg        - segments {g,f,e,d,c,b,a}, active-low
//               dp         - decimal point, active-low, always off
//               high_score - best final score since reset
//               new_high   - last game beat the previous high score
//               bcd_value  - five BCD digits of the last converted value
// Revision    : 1.0 - initial release
// ============================================================================
module score_display #(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] score_in,
  input  logic        gameover,
  input  logic        show_high,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [15:0] high_score,
  output logic        new_high,
  output logic [19:0] bcd_value
);

  localparam int              CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_e;

  // Game-end capture
  logic        gameover_q;
  logic [15:0] final_score_q, final_score_d;
  logic [15:0] high_score_q,  high_score_d;
  logic        new_high_q,    new_high_d;
  logic        capture;

  // Converter
  conv_state_e state_q, state_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_work_q, bcd_work_d;
  logic [3:0]  shift_cnt_q, shift_cnt_d;
  logic [19:0] bcd_value_q, bcd_value_d;
  logic [19:0] bcd_adj;
  logic [15:0] source;

  // Scanner
  logic [CNT_W-1:0] refresh_q, refresh_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [19:0]      upper;
  logic [3:0]       nib;
  logic             blank;

  // ---------------------------------------------------------------- capture
  assign capture = gameover & ~gameover_q;

  always_comb begin
    final_score_d = final_score_q;
    high_score_d  = high_score_q;
    new_high_d    = new_high_q;
    if (capture) begin
      final_score_d = score_in;
      if (score_in > high_score_q) begin
        high_score_d = score_in;
        new_high_d   = 1'b1;
      end
    end else if (!gameover && gameover_q) begin
      new_high_d = 1'b0;
    end
  end

  // -------------------------------------------------------------- converter
  always_comb begin
    if (show_high)       source = high_score_q;
    else if (gameover_q) source = final_score_q;
    else                 source = score_in;
  end

  // Double-dabble correction: any nibble >= 5 would overflow past 9 after
  // the doubling shift, so pre-add 3.
  always_comb begin
    bcd_adj = bcd_work_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_work_d  = bcd_work_q;
    shift_cnt_d = shift_cnt_q;
    bcd_value_d = bcd_value_q;
    case (state_q)
      ST_IDLE: state_d = ST_LOAD;
      ST_LOAD: begin
        bin_d       = source;
        bcd_work_d  = '0;
        shift_cnt_d = '0;
        state_d     = ST_SHIFT;
      end
      ST_SHIFT: begin
        bcd_work_d  = {bcd_adj[18:0], bin_q[15]};
        bin_d       = {bin_q[14:0], 1'b0};
        shift_cnt_d = shift_cnt_q + 4'd1;
        if (shift_cnt_q == 4'd15) state_d = ST_DONE;
      end
      ST_DONE: begin
        bcd_value_d = bcd_work_q;
        state_d     = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- scanner
  always_comb begin
    refresh_d = refresh_q + 1'b1;
    idx_d     = idx_q;
    if (refresh_q == CNT_MAX) begin
      refresh_d = '0;
      idx_d     = idx_q + 3'd1;
    end
  end

  // The value shifted down to the current digit: its low nibble is the digit,
  // and the whole word being zero means this and all higher digits are zero.
  always_comb begin
    upper = bcd_value_q >> {idx_q, 2'b00};
    nib   = upper[3:0];
    blank = (idx_q >= 3'd5) ||
            (BLANK_LEADING && (idx_q != 3'd0) && (upper == 20'd0));
  end

  always_comb begin
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    if (!blank) begin
      an_d = ~(8'd1 << idx_q);
      case (nib)
        4'd0:    seg_d = 7'h40;
        4'd1:    seg_d = 7'h79;
        4'd2:    seg_d = 7'h24;
        4'd3:    seg_d = 7'h30;
        4'd4:    seg_d = 7'h19;
        4'd5:    seg_d = 7'h12;
        4'd6:    seg_d = 7'h02;
        4'd7:    seg_d = 7'h78;
        4'd8:    seg_d = 7'h00;
        4'd9:    seg_d = 7'h10;
        default: seg_d = 7'h7F;
      endcase
    end
  end

  // -------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gameover_q    <= 1'b0;
      final_score_q <= '0;
      high_score_q  <= '0;
      new_high_q    <= 1'b0;
      state_q       <= ST_IDLE;
      bin_q         <= '0;
      bcd_work_q    <= '0;
      shift_cnt_q   <= '0;
      bcd_value_q   <= '0;
      refresh_q     <= '0;
      idx_q         <= '0;
      an_q          <= 8'hFF;
      seg_q         <= 7'h7F;
    end else begin
      gameover_q    <= gameover;
      final_score_q <= final_score_d;
      high_score_q  <= high_score_d;
      new_high_q    <= new_high_d;
      state_q       <= state_d;
      bin_q         <= bin_d;
      bcd_work_q    <= bcd_work_d;
      shift_cnt_q   <= shift_cnt_d;
      bcd_value_q   <= bcd_value_d;
      refresh_q     <= refresh_d;
      idx_q         <= idx_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign high_score = high_score_q;
  assign new_high   = new_high_q;
  assign bcd_value  = bcd_value_q;

endmodule
`default_nettype wire

// File: tb/tb_score_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_display
// Description : Directed self-checking bench for score_display with a short
//               refresh divider so full display scans fit in a few cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] score_in;
  logic        gameover;
  logic        show_high;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] high_score;
  logic        new_high;
  logic [19:0] bcd_value;

  int n_checks = 0;
  int n_fail   = 0;

  score_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .score_in   (score_in),
    .gameover   (gameover),
    .show_high  (show_high),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .high_score (high_score),
    .new_high   (new_high),
    .bcd_value  (bcd_value)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Poll bcd_value on falling edges for up to 'budget' cycles, then compare.
  task automatic wait_bcd(input string tag, input logic [19:0] exp, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bcd_value == exp) break;
    end
    check_eq(tag, {12'd0, bcd_value}, {12'd0, exp});
  endtask

  // Observe one full scan plus margin. 'on' marks digits that must light,
  // 'segs' holds their expected codes (digit i at [7*i +: 7]).
  task automatic scan_check(input string tag, input logic [7:0] on, input logic [55:0] segs);
    logic [7:0]  seen;
    logic [55:0] got_seg;
    int          bad_blank;
    int          bad_an;
    seen = '0; got_seg = '0; bad_blank = 0; bad_an = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (an == 8'hFF) begin
        if (seg != 7'h7F) bad_blank++;
      end else begin
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
          if (an == ~(8'd1 << i)) begin
            seen[i] = 1'b1;
            got_seg[7*i +: 7] = seg;
            hit = 1'b1;
          end
        end
        if (!hit) bad_an++;
      end
    end
    check_eq($sformatf("%s_blank_seg", tag), bad_blank, 0);
    check_eq($sformatf("%s_an_onehot", tag), bad_an, 0);
    check_eq($sformatf("%s_lit_digits", tag), {24'd0, seen}, {24'd0, on});
    for (int i = 0; i < 8; i++) begin
      if (on[i]) check_eq($sformatf("%s_seg%0d", tag, i), {25'd0, got_seg[7*i +: 7]},
                          {25'd0, segs[7*i +: 7]});
    end
  endtask

  initial begin
    reset     = 1'b0;
    score_in  = 16'd65340;
    gameover  = 1'b0;
    show_high = 1'b0;

    // 1. reset state, conversion latency, full scan of 65340
    repeat (3) @(negedge clk);
    check_eq("rst_an",       {24'd0, an},  32'hFF);
    check_eq("rst_seg",      {25'd0, seg}, 32'h7F);
    check_eq("rst_dp",       {31'd0, dp},  32'd1);
    check_eq("rst_high",     {16'd0, high_score}, 32'd0);
    check_eq("rst_new_high", {31'd0, new_high}, 32'd0);
    check_eq("rst_bcd",      {12'd0, bcd_value}, 32'd0);
    reset = 1'b1;
    repeat (17) @(negedge clk);
    check_eq("lat_early_bcd", {12'd0, bcd_value}, 32'd0);
    wait_bcd("bcd_65340", 20'h65340, 10);
    check_eq("dp_off", {31'd0, dp}, 32'd1);
    // digits 0..4 = 0,4,3,5,6
    scan_check("scan_65340", 8'h1F,
               {7'h7F, 7'h7F, 7'h7F, 7'h02, 7'h12, 7'h30, 7'h19, 7'h40});

    // 2. capture 40000, hold gameover, live score changes
    score_in = 16'd40000;
    wait_bcd("bcd_live_40000", 20'h40000, 40);
    gameover = 1'b1;
    @(negedge clk);
    check_eq("cap1_high",     {16'd0, high_score}, 32'd40000);
    check_eq("cap1_new_high", {31'd0, new_high}, 32'd1);
    score_in = 16'd100;
    repeat (40) @(negedge clk);
    check_eq("cap1_bcd_final", {12'd0, bcd_value}, 32'h40000);
    check_eq("cap1_hold_new_high", {31'd0, new_high}, 32'd1);
    check_eq("cap1_hold_high", {16'd0, high_score}, 32'd40000);

    // 3. second game, lower score; then show the high score
    gameover = 1'b0;
    @(negedge clk);
    check_eq("fall_clear_new_high", {31'd0, new_high}, 32'd0);
    score_in = 16'd30000;
    repeat (2) @(negedge clk);
    gameover = 1'b1;
    @(negedge clk);
    check_eq("cap2_high",     {16'd0, high_score}, 32'd40000);
    check_eq("cap2_new_high", {31'd0, new_high}, 32'd0);
    wait_bcd("cap2_bcd_final", 20'h30000, 40);
    show_high = 1'b1;
    wait_bcd("show_high_bcd", 20'h40000, 36);
    show_high = 1'b0;

    // 4. tie with the high score
    gameover = 1'b0;
    score_in = 16'd40000;
    repeat (2) @(negedge clk);
    gameover = 1'b1;
    @(negedge clk);
    check_eq("tie_high",     {16'd0, high_score}, 32'd40000);
    check_eq("tie_new_high", {31'd0, new_high}, 32'd0);
    wait_bcd("tie_bcd", 20'h40000, 40);

    // 5. leading-zero blanking
    gameover = 1'b0;
    score_in = 16'd42;
    wait_bcd("bcd_42", 20'h00042, 40);
    scan_check("scan_42", 8'h03, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});
    score_in = 16'd0;
    wait_bcd("bcd_0", 20'h00000, 40);
    scan_check("scan_0", 8'h01, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});

    // maximum value beats the high score
    score_in = 16'd65535;
    @(negedge clk);
    gameover = 1'b1;
    @(negedge clk);
    check_eq("max_high",     {16'd0, high_score}, 32'd65535);
    check_eq("max_new_high", {31'd0, new_high}, 32'd1);
    wait_bcd("max_bcd", 20'h65535, 40);
    gameover = 1'b0;

    // 6. reset mid-operation, gameover high at release
    score_in = 16'd12345;
    wait_bcd("bcd_12345", 20'h12345, 40);
    repeat (7) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_eq("mid_rst_an",   {24'd0, an},  32'hFF);
    check_eq("mid_rst_seg",  {25'd0, seg}, 32'h7F);
    check_eq("mid_rst_high", {16'd0, high_score}, 32'd0);
    check_eq("mid_rst_bcd",  {12'd0, bcd_value}, 32'd0);
    check_eq("mid_rst_new_high", {31'd0, new_high}, 32'd0);
    gameover = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rel_cap_high",     {16'd0, high_score}, 32'd12345);
    check_eq("rel_cap_new_high", {31'd0, new_high}, 32'd1);
    repeat (16) @(negedge clk);
    check_eq("rel_lat_early_bcd", {12'd0, bcd_value}, 32'd0);
    wait_bcd("rel_bcd", 20'h12345, 10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/score_display.md
Name: score_display

Overview:
- Consumer end of the score path: takes the live 16-bit score from the score counter and the gameover flag.
- Latches the final score at game end and keeps a session high score.
- Converts the selected value to BCD with a sequential double-dabble engine.
- Drives the board's 8-digit multiplexed seven-segment display.

Parameters:
- REFRESH_DIV, default 100000, clk cycles each digit stays lit (1 ms at 100 MHz).
- BLANK_LEADING, default 1, 1 = blank leading zeros (digit 0 is never blanked).

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-low reset
- score_in  input  16  live score from the score counter
- gameover  input  1  level; high while game is over
- show_high  input  1  1 = display high score instead of current/final score
- an  output  8  digit anodes, active-low, an[0] = rightmost digit
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low; held 1 (off)
- high_score  output  16  best final score since reset
- new_high  output  1  set when the last game beat high_score
- bcd_value  output  20  five BCD digits of the value last converted

Behaviour:
- Reset (reset=0, async):
  - an=8'hFF, seg=7'h7F, dp=1, high_score=0, new_high=0, bcd_value=0.
  - final_score=0, gameover_q=0, converter=IDLE, refresh counter=0, digit index=0.
- Game-end capture:
  - gameover_q registers gameover; a rising edge (gameover & ~gameover_q) is one capture cycle.
  - On capture: final_score <= score_in.
  - If score_in > high_score (strict, unsigned), high_score <= score_in and new_high <= 1 on the same edge.
  - Equal score: no update, new_high stays 0.
  - Holding gameover high captures only once.
  - Falling edge of gameover clears new_high.
- Source select, sampled at converter load:
  - show_high=1: high_score.
  - else gameover_q=1: final_score.
  - else: score_in (live).
- Converter FSM:
  - IDLE -> LOAD: unconditional, next cycle. Free-running; converts continuously.
  - LOAD: bin <= source, bcd_work <= 0, shift count <= 0.
  - SHIFT, 16 cycles: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd_work, bin} left by 1.
  - DONE: bcd_value <= bcd_work, then -> LOAD.
  - Latency from source sample to bcd_value update is 18 cycles. bcd_value only changes in DONE, so it never shows a partial result.
  - The source is sampled only in LOAD; changes mid-conversion are picked up by the next conversion.
- Scanner:
  - Refresh counter counts 0..REFRESH_DIV-1; on wrap, digit index increments 0..7 and wraps to 0.
  - an = ~(1 << index).
  - Digits 0..4 show bcd_value[4i+3:4i]; digits 5..7 are always blank.
  - A blank digit drives seg=7'h7F and its anode stays high.
  - Leading-zero blanking (BLANK_LEADING=1): digit i>0 is blank when it and all higher digits are 0.
  - Hex-to-segment decode is registered: seg/an update 1 cycle after the index changes.
  - Segment codes: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
- Reset mid-operation:
  - An in-flight conversion is discarded; the converter restarts from IDLE after reset releases.
  - The capture edge detector restarts with gameover_q=0. If gameover is high at release, a capture fires on the first clock.

Test Plan:
1. Reset, bench uses REFRESH_DIV=4; score_in=16'd65340, gameover=0 -> within 18 cycles bcd_value=20'h65340; scan shows digits 0..4 = 0,4,3,5,6 with an=FE,FD,FB,F7,EF; digits 5..7 give an=FF, seg=7F.
2. Capture: score_in=40000, pulse gameover high and hold -> final_score=40000, high_score=40000, new_high=1; score_in then changes to 100 but bcd_value stays 20'h40000; no second capture.
3. Second game: gameover low (new_high clears), score_in=30000, gameover rises -> high_score stays 40000, new_high=0, bcd_value=20'h30000; show_high=1 -> bcd_value=20'h40000 within 36 cycles.
4. Tie: final score 40000 equal to high_score -> no update, new_high=0.
5. Leading zeros: score_in=42 -> digit0 seg=7'h24, digit1 seg=7'h19, digits 2..7 an=FF; score_in=0 -> digit0 shows 7'h40, all others blank.
6. Assert reset mid-SHIFT and during an active digit -> an=FF, seg=7F, high_score=0, bcd_value=0 immediately; after release, first valid bcd_value appears 18+ cycles later.
